// File: rtl/sass_gpio_frontend_pkg.sv
// sass_gpio_pkg: default configuration shared by the GPIO front end (pin map and debounce length)
package sass_gpio_pkg;
  localparam int NUM_PINS  = 34;
  localparam int NUM_IN    = 18;
  localparam int NUM_OUT   = 12;
  localparam int OUT_BASE  = 18;
  localparam int DB_CNT_W  = 16;
  localparam int DB_CYCLES = 50000;
endpackage

// File: rtl/sass_gpio_frontend_if.sv
// sass_gpio_frontend_if: core-side bus of the GPIO front end
//   ncs      chip select, active low (core -> frontend)
//   core_out output channel values     (core -> frontend)
//   in_level clean input levels        (frontend -> core)
//   in_rise  one-cycle rising pulses   (frontend -> core)
interface sass_gpio_frontend_if #(
  parameter int NUM_IN  = sass_gpio_pkg::NUM_IN,
  parameter int NUM_OUT = sass_gpio_pkg::NUM_OUT
);
  logic               ncs;
  logic [NUM_OUT-1:0] core_out;
  logic [NUM_IN-1:0]  in_level;
  logic [NUM_IN-1:0]  in_rise;
  modport master (output ncs, core_out, input in_level, in_rise);
  modport slave (input ncs, core_out, output in_level, in_rise);
endinterface

// File: rtl/sass_gpio_frontend_debounce.sv
// sass_debounce: one input channel -- 2-flop synchronizer, debounce counter, clean level, rise pulse
//   clk, n_rst  clock and asynchronous active-low reset
//   ncs         chip select; while high the level holds, the count is held at 0, rise is 0
//   pin         raw pad input
//   level, rise clean level and one-cycle rising-edge pulse
//   SASS_GPIO_DEBOUNCE_EN defined builds the counter; otherwise level follows the synchronizer
module sass_debounce
  import sass_gpio_pkg::*;
#(
  parameter int DB_CNT_W  = sass_gpio_pkg::DB_CNT_W,
  parameter int DB_CYCLES = sass_gpio_pkg::DB_CYCLES
) (
  input  logic clk,
  input  logic n_rst,
  input  logic ncs,
  input  logic pin,
  output logic level,
  output logic rise
);
  logic [1:0] sync_q;
  logic       rise_q;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) sync_q <= '0;
    else sync_q <= {sync_q[0], pin};
`ifdef SASS_GPIO_DEBOUNCE_EN
  localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DB_CYCLES - 1);
  logic [DB_CNT_W-1:0] cnt;
  logic                differ;
  logic                done;
  assign differ = sync_q[1] ^ level;
  // the count only reaches LAST while differing, so it can never wrap
  assign done   = ~ncs & differ & (cnt == LAST);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      cnt    <= '0;
      level  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt    <= (ncs | ~differ | done) ? '0 : cnt + 1'b1;
      level  <= done ? sync_q[1] : level;
      rise_q <= done & sync_q[1];
    end
`else
  // level registers the first stage so it tracks the second stage exactly (2-clock latency)
  logic unused_cfg;
  assign unused_cfg = ^{sync_q[1], DB_CNT_W, DB_CYCLES};
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      level  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      level  <= ncs ? level : sync_q[0];
      rise_q <= ~ncs & sync_q[0] & ~level;
    end
`endif
  // a pulse registered just before ncs rises must not leak into the frozen window
  assign rise = rise_q & ~ncs;
endmodule

// File: rtl/sass_gpio_frontend.sv
// sass_gpio_frontend: GPIO breakout front end -- debounced inputs to the core, registered outputs to pads
//   clk, n_rst  clock and asynchronous active-low reset
//   bus         core-side bus (ncs, core_out, in_level, in_rise), slave modport
//   gpio_in     raw pad inputs, channels on [NUM_IN-1:0]
//   gpio_out    pad outputs, out_q on [OUT_BASE+NUM_OUT-1:OUT_BASE], zero elsewhere
//   gpio_oeb    constant active-low output enables for the output window
//   SASS_GPIO_DEBOUNCE_EN selects debounced inputs; undefined gives plain synchronized inputs
module sass_gpio_frontend
  import sass_gpio_pkg::*;
#(
  parameter int NUM_PINS  = sass_gpio_pkg::NUM_PINS,
  parameter int NUM_IN    = sass_gpio_pkg::NUM_IN,
  parameter int NUM_OUT   = sass_gpio_pkg::NUM_OUT,
  parameter int OUT_BASE  = sass_gpio_pkg::OUT_BASE,
  parameter int DB_CNT_W  = sass_gpio_pkg::DB_CNT_W,
  parameter int DB_CYCLES = sass_gpio_pkg::DB_CYCLES
) (
  input  logic                clk,
  input  logic                n_rst,
  sass_gpio_frontend_if.slave bus,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [NUM_PINS-1:0] gpio_out,
  output logic [NUM_PINS-1:0] gpio_oeb
);
  logic [NUM_OUT-1:0] out_q;
  logic               unused_pins;
  assign unused_pins = ^gpio_in[NUM_PINS-1:NUM_IN];
  for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
    sass_debounce #(
      .DB_CNT_W (DB_CNT_W),
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .n_rst(n_rst),
      .ncs  (bus.ncs),
      .pin  (gpio_in[i]),
      .level(bus.in_level[i]),
      .rise (bus.in_rise[i])
    );
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) out_q <= '0;
    else out_q <= bus.ncs ? '0 : bus.core_out;
  assign gpio_out = NUM_PINS'(out_q) << OUT_BASE;
  assign gpio_oeb = ~(NUM_PINS'({NUM_OUT{1'b1}}) << OUT_BASE);
endmodule

// File: tb/tb_sass_gpio_frontend.sv
// tb_sass_gpio_frontend: randomized and directed checks of sass_gpio_frontend against a behavioural model
module tb_sass_gpio_frontend;
  localparam int DB = 4;
`ifdef SASS_GPIO_DEBOUNCE_EN
  localparam int LAT = DB + 2;
`else
  localparam int LAT = 2;
`endif
  localparam logic [33:0] OEB = 34'h3_C003_FFFF;
  logic        clk = 1'b0;
  logic        n_rst;
  logic [33:0] gpio_in;
  logic [33:0] gpio_out;
  logic [33:0] gpio_oeb;
  sass_gpio_frontend_if bus ();
  sass_gpio_frontend #(.DB_CYCLES(DB)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .bus     (bus),
    .gpio_in (gpio_in),
    .gpio_out(gpio_out),
    .gpio_oeb(gpio_oeb)
  );
  always #5 clk = ~clk;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [17:0] m_s1, m_s2, m_lvl, m_rise;
  int          m_run [18];
  logic [11:0] m_out;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model_clear();
    m_s1 = '0;
    m_s2 = '0;
    m_lvl = '0;
    m_rise = '0;
    m_out = '0;
    foreach (m_run[i]) m_run[i] = 0;
  endfunction
  // one clock edge: a level changes once the synchronized pin has disagreed with it for DB
  // consecutive selected cycles (or immediately without debouncing)
  function automatic void model_step();
    if (!n_rst) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 18; i++) begin
      m_rise[i] = 1'b0;
`ifdef SASS_GPIO_DEBOUNCE_EN
      if (bus.ncs || m_s2[i] == m_lvl[i]) m_run[i] = 0;
      else begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = m_s2[i];
          m_rise[i] = m_s2[i];
          m_run[i] = 0;
        end
      end
`else
      if (!bus.ncs) begin
        m_rise[i] = m_s1[i] & ~m_lvl[i];
        m_lvl[i] = m_s1[i];
      end
`endif
    end
    m_s2 = m_s1;
    m_s1 = gpio_in[17:0];
    m_out = bus.ncs ? 12'h000 : bus.core_out;
  endfunction
  task automatic compare_all();
    check("in_level", 64'(bus.in_level), 64'(m_lvl));
    check("in_rise", 64'(bus.in_rise), 64'(m_rise & {18{~bus.ncs}}));
    check("gpio_out", 64'(gpio_out), 64'({4'b0, m_out, 18'b0}));
    check("gpio_oeb", 64'(gpio_oeb), 64'(OEB));
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask
  task automatic step_in(input int ch);
    gpio_in[ch] = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      check("step_level", 64'(bus.in_level[ch]), 64'(k >= LAT));
      check("step_rise", 64'(bus.in_rise[ch]), 64'(k == LAT));
    end
  endtask
  initial begin
    logic seen;
    n_rst = 1'b0;
    gpio_in = '1;
    bus.ncs = 1'b0;
    bus.core_out = '0;
    model_clear();
    @(negedge clk);
    tick();
    tick();
    check("rst_level", 64'(bus.in_level), 64'(0));
    check("rst_out", 64'(gpio_out), 64'(0));
    check("rst_oeb", 64'(gpio_oeb), 64'(OEB));
    gpio_in = '0;
    n_rst = 1'b1;
    repeat (8) tick();
    step_in(3);
    gpio_in[5] = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen |= bus.in_rise[5];
    end
    gpio_in[5] = 1'b0;
    repeat (8) begin
      tick();
      seen |= bus.in_rise[5];
    end
    check("glitch_level", 64'(bus.in_level[5]), 64'(0));
    check("glitch_rise", 64'(seen), 64'(LAT == 2));
    bus.core_out = 12'hA5A;
    tick();
    check("cs_out", 64'(gpio_out[29:18]), 64'(12'hA5A));
    bus.ncs = 1'b1;
    tick();
    check("cs_off", 64'(gpio_out), 64'(0));
    gpio_in[9] = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      seen |= bus.in_rise[9];
    end
    check("cs_rise", 64'(seen), 64'(0));
    check("cs_hold", 64'(bus.in_level[9]), 64'(0));
    bus.ncs = 1'b0;
    repeat (LAT + 1) tick();
    check("cs_resume", 64'(bus.in_level[9]), 64'(1));
    gpio_in[0] = 1'b1;
    repeat (3) tick();
    n_rst = 1'b0;
    model_clear();
    tick();
    check("rst_mid", 64'(bus.in_level), 64'(0));
    n_rst = 1'b1;
    step_in(0);
    gpio_in[7] = 1'b1;
    tick();
    gpio_in[7] = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("pulse_level", 64'(bus.in_level[7]), 64'(LAT == 2 && k == 2));
    end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 18; i++) if ($urandom_range(0, 9) == 0) gpio_in[i] = ~gpio_in[i];
      gpio_in[33:18] = 16'($urandom);
      if ($urandom_range(0, 15) == 0) bus.ncs = ~bus.ncs;
      bus.core_out = 12'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        n_rst = 1'b0;
        model_clear();
        tick();
        n_rst = 1'b1;
      end
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sass_gpio_frontend.md
SASS_GPIO_FRONTEND -- requirements
Module: sass_gpio_frontend

Interface
REQ-001 SHALL have parameter NUM_PINS, default 34: breakout GPIO count.
REQ-002 SHALL have parameter NUM_IN, default 18: input channels on gpio_in[NUM_IN-1:0].
REQ-003 SHALL have parameter NUM_OUT, default 12: output channels.
REQ-004 SHALL have parameter OUT_BASE, default 18: lowest output pin; legal only if OUT_BASE>=NUM_IN and OUT_BASE+NUM_OUT<=NUM_PINS.
REQ-005 SHALL have parameter DB_CNT_W, default 16: debounce counter width.
REQ-006 SHALL have parameter DB_CYCLES, default 50000: required stable cycles; legal range 1..2**DB_CNT_W-1.
REQ-007 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-008 SHALL have port n_rst, input, 1: asynchronous active-low reset.
REQ-009 SHALL have port ncs, input, 1: chip select, active low.
REQ-010 SHALL have port gpio_in, input, NUM_PINS: raw asynchronous pad inputs.
REQ-011 SHALL have port gpio_out, output, NUM_PINS: pad outputs.
REQ-012 SHALL have port gpio_oeb, output, NUM_PINS: active-low output enable.
REQ-013 SHALL have port in_level, output, NUM_IN: clean per-channel level to core.
REQ-014 SHALL have port in_rise, output, NUM_IN: one-cycle rising-edge pulse to core.
REQ-015 SHALL have port core_out, input, NUM_OUT: core output values.

Function
REQ-016 Each input channel SHALL pass through a 2-flop synchronizer (sync_q) before any other logic.
REQ-017 Debounce: counter SHALL clear while sync_q==in_level, increment while they differ, and on the cycle the count equals DB_CYCLES-1 with sync_q still differing, in_level SHALL take sync_q and the counter SHALL clear.
REQ-018 Pin-to-in_level latency SHALL be exactly DB_CYCLES+2 clocks for a clean step held that long.
REQ-019 Any pad glitch shorter than DB_CYCLES synchronized cycles SHALL leave in_level unchanged and restart the count.
REQ-020 in_rise[i] SHALL be high for exactly the one cycle after in_level[i] changes 0->1; falling edges produce no pulse.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each resolve on their own schedule.
REQ-022 Output register: out_q SHALL load core_out each cycle while ncs=0 and SHALL load all-zero while ncs=1; latency core_out->gpio_out is 1 clock.
REQ-023 gpio_out[OUT_BASE+NUM_OUT-1:OUT_BASE] SHALL equal out_q; all other gpio_out bits SHALL be 0.
REQ-024 gpio_oeb SHALL be 0 on bits OUT_BASE..OUT_BASE+NUM_OUT-1 and 1 elsewhere, constant, including during reset.
REQ-025 While ncs=1: in_level SHALL hold, in_rise SHALL be 0, debounce counters SHALL be held at 0; synchronizers keep running.
REQ-026 On ncs 1->0 debouncing SHALL resume from count 0 against the held in_level.
REQ-027 Counter SHALL never wrap; it saturates by construction at DB_CYCLES-1.

Reset
REQ-028 n_rst=0 SHALL asynchronously clear sync flops, counters, in_level, in_rise, out_q to 0; mid-debounce progress is discarded.
REQ-029 Release SHALL be synchronous to clk; first in_level update requires a full DB_CYCLES+2 window after release.

Configuration
REQ-030 Macro SASS_GPIO_DEBOUNCE_EN defined: REQ-017..REQ-019 behaviour.
REQ-031 Macro absent: counters SHALL not be built; in_level SHALL equal sync_q (latency 2 clocks), in_rise derived from it identically, ncs freeze of REQ-025 retained.

Structure
REQ-032 Package sass_gpio_pkg SHALL hold default parameter constants (NUM_PINS, NUM_IN, NUM_OUT, OUT_BASE, DB_CNT_W, DB_CYCLES).
REQ-033 One sub-module sass_debounce SHALL implement a single channel (synchronizer, counter, level, rise), instantiated NUM_IN times.

Verification (bench uses DB_CYCLES=4, macro defined unless stated)
REQ-034 Reset: n_rst=0, gpio_in all 1 -> in_level=0, in_rise=0, gpio_out=0, gpio_oeb=34'h3_C003_FFFF.
REQ-035 Clean step: gpio_in[3] 0->1 held -> in_level[3]=1 exactly 6 clocks later, in_rise[3] high 1 cycle.
REQ-036 Glitch: gpio_in[5] high 3 cycles then low -> in_level[5] stays 0, no in_rise.
REQ-037 Chip select: core_out=12'hA5A with ncs=0 -> gpio_out[29:18]=12'hA5A next cycle; ncs=1 -> gpio_out=0 next cycle, in_rise stays 0 on input step.
REQ-038 Reset mid-count: gpio_in[0] high 3 cycles, pulse n_rst low -> in_level[0]=0, full 6 clocks required after release.
REQ-039 Macro undefined: gpio_in[7] 1-cycle pulse -> in_level[7] high 1 cycle after 2-clock latency.
